player_motion_ctrl: RTL and testbench
=====================================

Name: player_motion_ctrl

Overview:
- Per-frame knight motion and animation-state controller. Sits directly upstream of the player colour mapper.
- Converts two USB keycode slots into the following registered outputs: Player_X, Player_Y (sprite centre), Player_Status (0 idle, 1 walk, 2 jump, 3 fall), Inverse (facing left) and the sprite sizes.
- Physics (walk step, jump impulse, gravity, floor/wall/ceiling clamps) advances once per vertical frame.

Parameters:
X_START, 320, reset X centre
Y_FLOOR, 400, ground Y centre
X_MIN, 24, left clamp
X_MAX, 615, right clamp
Y_CEIL, 32, ceiling clamp
WALK_STEP, 3, pixels per frame horizontally
JUMP_VEL, 12, initial upward speed (px/frame)
GRAVITY, 1, speed increment per frame
VMAX, 12, terminal fall speed
SIZE_X, 50, sprite width
SIZE_Y, 64, sprite height

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous, active-low reset
frame_clk  in  1  vsync-rate frame strobe, asynchronous to Clk
keycode0  in  8  USB keycode slot 0
keycode1  in  8  USB keycode slot 1
Player_X  out  10  sprite centre X
Player_Y  out  10  sprite centre Y
Player_Status  out  4  animation state 0..3
Inverse  out  1  1 = facing left
Player_SizeX  out  10  constant SIZE_X
Player_SizeY  out  10  constant SIZE_Y

Behaviour:
- Reset: one clock, synchronous, active-low (Reset_n sampled on rising Clk). While low, on every edge:
  - Player_X=X_START, Player_Y=Y_FLOOR, Player_Status=0, Inverse=0.
  - vy=0, jump_prev=0, state IDLE.
  - A reset mid-air snaps the player to the floor on the next edge.
- frame_tick: frame_clk passes through a 2-flop synchroniser plus rising-edge detect. Result is a 1-Clk pulse, 3 Clk after the frame_clk rise.
- Update rule: all state/output updates occur only on Clk edges with frame_tick=1. Outputs are registered and change 1 Clk after the tick.
- Key decode: a key is pressed if either slot matches. Left=A, right=D, jump=W or SPACE.
  - jump_edge = jump & ~jump_prev; jump_prev is updated on each tick.
  - Holding jump gives exactly one jump.
- Horizontal (all states, each tick):
  - left only: X-=WALK_STEP, Inverse=1.
  - right only: X+=WALK_STEP, Inverse=0.
  - both or neither: no move, Inverse held.
  - Result is saturated to [X_MIN,X_MAX]; computed in 11-bit signed, so no wrap at 0.
- Vertical: vy is signed 6-bit; Y is computed in 11-bit signed before clamping.
- FSM:
  - IDLE(0): jump_edge -> JUMP with vy=-JUMP_VEL, Y unchanged. Else moving -> WALK.
  - WALK(1): jump_edge -> JUMP with vy=-JUMP_VEL. Not moving -> IDLE.
  - JUMP(2): Y+=vy, then vy+=GRAVITY. If the new vy>=0 -> FALL. If Y+vy<Y_CEIL: Y=Y_CEIL, vy=0, -> FALL.
  - FALL(3): vy=min(vy+GRAVITY,VMAX), then Y+=vy. If result>=Y_FLOOR: Y=Y_FLOOR, vy=0, -> WALK if moving else IDLE.
- Airborne input: jump_edge in JUMP/FALL is ignored, but still updates jump_prev.
- Simultaneous landing and jump press: landing wins on that tick; a new jump needs a fresh edge.
- Sizes: Player_SizeX and Player_SizeY are constants, driven through reset.

Optional Feature:
PLAYER_DOUBLE_JUMP_EN:
- Defined: one extra jump_edge is accepted in JUMP or FALL. It sets vy=-JUMP_VEL and state JUMP. The extra jump is re-armed on landing or reset.
- Undefined: airborne jumps are ignored.

Decomposition:
- player_pkg holds:
  - status enum: IDLE=0, WALK=1, JUMP=2, FALL=3, as 4-bit.
  - key constants: KEY_A=8'h04, KEY_D=8'h07, KEY_W=8'h1A, KEY_SPACE=8'h2C.
- Sub-module frame_tick_gen holds the synchroniser plus edge detect (Clk, Reset_n, frame_clk -> frame_tick).

Test Plan:
- Reset: Reset_n low 2 cycles -> X=320, Y=400, Status=0, Inverse=0. Sizes 50/64.
- Walk left: keycode0=04 for 10 ticks -> X=290, Inverse=1, Status=1. Release -> Status=0 on next tick, Inverse stays 1.
- Wall clamp: hold D from X=612 -> X=615 after one tick, stays 615, Status=1.
- Full jump: tap W from idle.
  - Tick1: Status=2, Y=400.
  - After 12 further ticks: Y=322, Status=3.
  - After 12 more ticks: Y=400, Status=0.
  - No overshoot below 400.
- Held jump: hold SPACE 40 ticks -> exactly one jump arc; re-press only after release starts a new arc.
- Reset mid-air: assert Reset_n low at Y=350 in FALL -> next edge Y=400, Status=0, vy=0.
- With PLAYER_DOUBLE_JUMP_EN: second W tap at apex -> Status=2, vy=-12. Third tap ignored until landing.

Source files
------------

// File: rtl/player_pkg.sv
// Shared types and constants for the knight motion controller:
// the animation-state encoding and the USB HID keycodes that drive it.
package player_pkg;

    // Animation / motion state, presented directly on Player_Status.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_WALK = 4'd1,
        ST_JUMP = 4'd2,
        ST_FALL = 4'd3
    } status_e;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    // A key counts as pressed when it appears in either keycode slot.
    function automatic logic key_hit(input logic [7:0] k0,
                                     input logic [7:0] k1,
                                     input logic [7:0] key);
        return (k0 == key) || (k1 == key);
    endfunction

endpackage

// File: rtl/player_motion_ctrl_frame_tick_gen.sv
// Brings the vsync-rate frame_clk into the Clk domain and turns each of
// its rising edges into a single-cycle frame_tick pulse.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic frame_tick
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Two-flop synchroniser, one delayed copy for edge detect, registered pulse.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            sync1      <= frame_clk;
            sync2      <= sync1;
            sync3      <= sync2;
            frame_tick <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame knight motion and animation-state controller.
// Walk, jump, gravity and floor/wall/ceiling clamps advance once per
// frame_tick; all outputs are registered.
// Optional build macro PLAYER_DOUBLE_JUMP_EN: allows one extra mid-air
// jump, re-armed on landing or reset.
module player_motion_ctrl
    import player_pkg::*;
#(
    parameter int X_START   = 320,
    parameter int Y_FLOOR   = 400,
    parameter int X_MIN     = 24,
    parameter int X_MAX     = 615,
    parameter int Y_CEIL    = 32,
    parameter int WALK_STEP = 3,
    parameter int JUMP_VEL  = 12,
    parameter int GRAVITY   = 1,
    parameter int VMAX      = 12,
    parameter int SIZE_X    = 50,
    parameter int SIZE_Y    = 64
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic [9:0] Player_X,
    output logic [9:0] Player_Y,
    output logic [3:0] Player_Status,
    output logic       Inverse,
    output logic [9:0] Player_SizeX,
    output logic [9:0] Player_SizeY
);

    // Signed working copies of the geometry; 11 bits keeps X-WALK_STEP
    // near zero and Y+vy near the ceiling from wrapping.
    localparam logic signed [10:0] X_MIN_S   = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S   = 11'(X_MAX);
    localparam logic signed [10:0] Y_CEIL_S  = 11'(Y_CEIL);
    localparam logic signed [10:0] Y_FLOOR_S = 11'(Y_FLOOR);
    localparam logic signed [10:0] STEP_S    = 11'(WALK_STEP);
    localparam logic signed [6:0]  GRAV_S    = 7'(GRAVITY);
    localparam logic signed [6:0]  VMAX_S    = 7'(VMAX);
    localparam logic signed [5:0]  VY_JUMP   = 6'(-JUMP_VEL);

    logic frame_tick;

    frame_tick_gen u_tick (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    status_e            state_q, state_d;
    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic signed [5:0]  vy_q, vy_d;
    logic               inv_q, inv_d;
    logic               jump_prev_q;

`ifdef PLAYER_DOUBLE_JUMP_EN
    logic armed_q, armed_d;
`endif

    logic left, right, jump, jump_edge, moving;
    logic signed [10:0] x_ext, y_ext, vy_ext, vyf_ext;
    logic signed [10:0] y_jump, y_fall;
    logic signed [6:0]  vy_inc, vy_fall;

    function automatic logic [9:0] clamp_x(input logic signed [10:0] v);
        if (v < X_MIN_S)
            return X_MIN_S[9:0];
        else if (v > X_MAX_S)
            return X_MAX_S[9:0];
        else
            return v[9:0];
    endfunction

    assign left      = key_hit(keycode0, keycode1, KEY_A);
    assign right     = key_hit(keycode0, keycode1, KEY_D);
    assign jump      = key_hit(keycode0, keycode1, KEY_W) |
                       key_hit(keycode0, keycode1, KEY_SPACE);
    assign jump_edge = jump & ~jump_prev_q;
    assign moving    = left ^ right;

    assign x_ext   = $signed({1'b0, x_q});
    assign y_ext   = $signed({1'b0, y_q});
    assign vy_ext  = $signed({{5{vy_q[5]}}, vy_q});
    assign vy_inc  = $signed({vy_q[5], vy_q}) + GRAV_S;
    assign vy_fall = (vy_inc > VMAX_S) ? VMAX_S : vy_inc;
    assign vyf_ext = $signed({{4{vy_fall[6]}}, vy_fall});
    assign y_jump  = y_ext + vy_ext;
    assign y_fall  = y_ext + vyf_ext;

    // Next-state and next-output computation for one frame step.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vy_d    = vy_q;
        inv_d   = inv_q;
`ifdef PLAYER_DOUBLE_JUMP_EN
        armed_d = armed_q;
`endif

        if (left && !right) begin
            x_d   = clamp_x(x_ext - STEP_S);
            inv_d = 1'b1;
        end else if (right && !left) begin
            x_d   = clamp_x(x_ext + STEP_S);
            inv_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (jump_edge) begin
                    state_d = ST_JUMP;
                    vy_d    = VY_JUMP;
                end else if (moving) begin
                    state_d = ST_WALK;
                end
            end
            ST_WALK: begin
                if (jump_edge) begin
                    state_d = ST_JUMP;
                    vy_d    = VY_JUMP;
                end else if (!moving) begin
                    state_d = ST_IDLE;
                end
            end
            ST_JUMP: begin
                if (y_jump < Y_CEIL_S) begin
                    y_d     = Y_CEIL_S[9:0];
                    vy_d    = 6'sd0;
                    state_d = ST_FALL;
                end else begin
                    y_d  = y_jump[9:0];
                    vy_d = vy_inc[5:0];
                    if (!vy_inc[6])
                        state_d = ST_FALL;
                end
`ifdef PLAYER_DOUBLE_JUMP_EN
                if (jump_edge && armed_q) begin
                    y_d     = y_q;
                    vy_d    = VY_JUMP;
                    state_d = ST_JUMP;
                    armed_d = 1'b0;
                end
`endif
            end
            default: begin
                // Landing takes precedence over any jump press on the same tick.
                if (y_fall >= Y_FLOOR_S) begin
                    y_d     = Y_FLOOR_S[9:0];
                    vy_d    = 6'sd0;
                    state_d = moving ? ST_WALK : ST_IDLE;
`ifdef PLAYER_DOUBLE_JUMP_EN
                    armed_d = 1'b1;
`endif
                end else begin
                    y_d  = y_fall[9:0];
                    vy_d = vy_fall[5:0];
`ifdef PLAYER_DOUBLE_JUMP_EN
                    if (jump_edge && armed_q) begin
                        y_d     = y_q;
                        vy_d    = VY_JUMP;
                        state_d = ST_JUMP;
                        armed_d = 1'b0;
                    end
`endif
                end
            end
        endcase
    end

    // State and output registers, advanced only on frame ticks.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            x_q         <= 10'(X_START);
            y_q         <= 10'(Y_FLOOR);
            vy_q        <= 6'sd0;
            inv_q       <= 1'b0;
            jump_prev_q <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            armed_q     <= 1'b1;
`endif
        end else if (frame_tick) begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            inv_q       <= inv_d;
            jump_prev_q <= jump;
`ifdef PLAYER_DOUBLE_JUMP_EN
            armed_q     <= armed_d;
`endif
        end
    end

    assign Player_X      = x_q;
    assign Player_Y      = y_q;
    assign Player_Status = state_q;
    assign Inverse       = inv_q;
    assign Player_SizeX  = 10'(SIZE_X);
    assign Player_SizeY  = 10'(SIZE_Y);

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed, table-driven bench for player_motion_ctrl with hand-written
// sequences for mid-air reset, landing-vs-jump and airborne jumps.
module tb_player_motion_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode0 = 8'h00;
    logic [7:0] keycode1 = 8'h00;
    logic [9:0] Player_X, Player_Y, Player_SizeX, Player_SizeY;
    logic [3:0] Player_Status;
    logic       Inverse;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] k0;
        logic [7:0] k1;
        int         n;
        int         x;
        int         y;
        int         st;
        int         inv;
    } vec_t;

    vec_t tbl[$];

    player_motion_ctrl dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_clk     (frame_clk),
        .keycode0      (keycode0),
        .keycode1      (keycode1),
        .Player_X      (Player_X),
        .Player_Y      (Player_Y),
        .Player_Status (Player_Status),
        .Inverse       (Inverse),
        .Player_SizeX  (Player_SizeX),
        .Player_SizeY  (Player_SizeY)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_all(input string name, input int x, input int y,
                              input int st, input int inv);
        chk({name, ".x"},   int'(Player_X), x);
        chk({name, ".y"},   int'(Player_Y), y);
        chk({name, ".st"},  int'(Player_Status), st);
        chk({name, ".inv"}, int'(Inverse), inv);
    endtask

    // One frame: frame_clk high 4 cycles then low 4; ends on a negedge
    // after the resulting update has landed.
    task automatic one_frame();
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic apply(input logic [7:0] k0, input logic [7:0] k1, input int n);
        keycode0 = k0;
        keycode1 = k1;
        for (int i = 0; i < n; i++) one_frame();
    endtask

    initial begin
        tbl.push_back('{8'h04, 8'h00,  10, 290, 400, 1, 1});
        tbl.push_back('{8'h00, 8'h00,   1, 290, 400, 0, 1});
        tbl.push_back('{8'h00, 8'h07,   1, 293, 400, 1, 0});
        tbl.push_back('{8'h04, 8'h07,   1, 293, 400, 0, 0});
        tbl.push_back('{8'h00, 8'h00,   2, 293, 400, 0, 0});
        tbl.push_back('{8'h07, 8'h00, 107, 614, 400, 1, 0});
        tbl.push_back('{8'h07, 8'h00,   1, 615, 400, 1, 0});
        tbl.push_back('{8'h00, 8'h07,   3, 615, 400, 1, 0});
        tbl.push_back('{8'h04, 8'h00, 200,  24, 400, 1, 1});
        tbl.push_back('{8'h00, 8'h00,   1,  24, 400, 0, 1});
        tbl.push_back('{8'h1A, 8'h00,   1,  24, 400, 2, 1});
        tbl.push_back('{8'h00, 8'h00,  12,  24, 322, 3, 1});
        tbl.push_back('{8'h00, 8'h00,  12,  24, 400, 0, 1});
        tbl.push_back('{8'h00, 8'h2C,   1,  24, 400, 2, 1});
        tbl.push_back('{8'h00, 8'h2C,  24,  24, 400, 0, 1});
        tbl.push_back('{8'h00, 8'h2C,  15,  24, 400, 0, 1});
        tbl.push_back('{8'h00, 8'h00,   1,  24, 400, 0, 1});
        tbl.push_back('{8'h2C, 8'h00,   1,  24, 400, 2, 1});
        tbl.push_back('{8'h00, 8'h00,  12,  24, 322, 3, 1});
        tbl.push_back('{8'h00, 8'h00,   7,  24, 350, 3, 1});

        // Reset held for two cycles.
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        expect_all("reset", 320, 400, 0, 0);
        chk("size_x", int'(Player_SizeX), 50);
        chk("size_y", int'(Player_SizeY), 64);
        Reset_n = 1'b1;

        // Keys alone must not move anything without a frame tick.
        keycode0 = 8'h04;
        repeat (20) @(negedge Clk);
        expect_all("no_tick", 320, 400, 0, 0);
        keycode0 = 8'h00;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].k0, tbl[i].k1, tbl[i].n);
            expect_all($sformatf("row%0d", i), tbl[i].x, tbl[i].y,
                       tbl[i].st, tbl[i].inv);
        end

        // Reset while falling at Y=350 snaps to floor on the next edge.
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        expect_all("midair_reset", 320, 400, 0, 0);
        Reset_n = 1'b1;
        apply(8'h00, 8'h00, 1);
        expect_all("post_reset_still", 320, 400, 0, 0);

        // Jump press on the landing tick: landing wins, held key gives no jump.
        apply(8'h1A, 8'h00, 1);
        expect_all("lj_takeoff", 320, 400, 2, 0);
        apply(8'h00, 8'h00, 12);
        expect_all("lj_apex", 320, 322, 3, 0);
        apply(8'h00, 8'h00, 11);
        expect_all("lj_low", 320, 388, 3, 0);
        apply(8'h1A, 8'h00, 1);
        expect_all("lj_land", 320, 400, 0, 0);
        apply(8'h1A, 8'h00, 1);
        expect_all("lj_held", 320, 400, 0, 0);
        apply(8'h00, 8'h00, 1);
        apply(8'h1A, 8'h00, 1);
        expect_all("lj_fresh", 320, 400, 2, 0);
        apply(8'h00, 8'h00, 12);
        expect_all("aj_apex", 320, 322, 3, 0);

        // Airborne jump presses at the apex.
`ifdef PLAYER_DOUBLE_JUMP_EN
        apply(8'h1A, 8'h00, 1);
        expect_all("dj_second", 320, 322, 2, 0);
        apply(8'h00, 8'h00, 1);
        expect_all("dj_rise", 320, 310, 2, 0);
        apply(8'h1A, 8'h00, 1);
        expect_all("dj_third", 320, 299, 2, 0);
`else
        apply(8'h1A, 8'h00, 1);
        expect_all("aj_ignored", 320, 323, 3, 0);
        apply(8'h00, 8'h00, 1);
        expect_all("aj_fall2", 320, 325, 3, 0);
        apply(8'h1A, 8'h00, 1);
        expect_all("aj_fall3", 320, 328, 3, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
